// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: turns camera byte pairs into 12-bit pixels with linear frame-buffer addresses.
// Define CAPTURE_STATS_EN to add a captured-frame counter and a sticky line-length checker.
`timescale 1ns/1ps
module ov7670_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  d,
  output logic [18:0] addr,
  output logic [11:0] dout,
  output logic        we,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        line_err
);

  localparam int          FRAME_PIXELS = H_PIXELS * V_LINES;
  localparam logic [18:0] LAST_ADDR    = 19'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;

  state_t      state_q, state_d;
  logic        vsync_r_q, vsync_r_d;
  logic        href_r_q, href_r_d;
  logic [7:0]  d_r_q, d_r_d;
  logic        second_q, second_d;
  logic [3:0]  red_q, red_d;
  logic        pend_q, pend_d;
  logic [11:0] pend_pix_q, pend_pix_d;
  logic [18:0] addr_q, addr_d;
  logic [11:0] dout_q, dout_d;
  logic        we_q, we_d;
  logic        full_q, full_d;
  logic        frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    vsync_r_d    = vsync;
    href_r_d     = href;
    d_r_d        = d;
    second_d     = second_q;
    red_d        = red_q;
    pend_d       = 1'b0;
    pend_pix_d   = pend_pix_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    we_d         = 1'b0;
    full_d       = full_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        second_d = 1'b0;
        if (vsync_r_q) state_d = SYNC;
      end
      SYNC: begin
        second_d = 1'b0;
        if (!vsync_r_q) state_d = CAPTURE;
      end
      CAPTURE: begin
        // vsync wins over any byte arriving on the same cycle
        if (vsync_r_q) begin
          state_d      = SYNC;
          frame_done_d = 1'b1;
          second_d     = 1'b0;
        end else if (href_r_q) begin
          if (!second_q) begin
            red_d    = d_r_q[3:0];
            second_d = 1'b1;
          end else begin
            pend_d     = 1'b1;
            pend_pix_d = {red_q, d_r_q};
            second_d   = 1'b0;
          end
        end else begin
          second_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Write stage: a completed pixel is emitted one cycle later unless the frame is full
    if (state_q == CAPTURE && !vsync_r_q && pend_q && !full_q &&
        !(we_q && addr_q == LAST_ADDR)) begin
      we_d   = 1'b1;
      dout_d = pend_pix_q;
    end

    if (we_q) begin
      if (addr_q == LAST_ADDR) full_d = 1'b1;
      else                     addr_d = addr_q + 19'd1;
    end

    if (state_d != CAPTURE) begin
      addr_d = '0;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= IDLE;
      vsync_r_q    <= 1'b0;
      href_r_q     <= 1'b0;
      d_r_q        <= '0;
      second_q     <= 1'b0;
      red_q        <= '0;
      pend_q       <= 1'b0;
      pend_pix_q   <= '0;
      addr_q       <= '0;
      dout_q       <= '0;
      we_q         <= 1'b0;
      full_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_r_q    <= vsync_r_d;
      href_r_q     <= href_r_d;
      d_r_q        <= d_r_d;
      second_q     <= second_d;
      red_q        <= red_d;
      pend_q       <= pend_d;
      pend_pix_q   <= pend_pix_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      we_q         <= we_d;
      full_q       <= full_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign addr       = addr_q;
  assign dout       = dout_q;
  assign we         = we_q;
  assign frame_done = frame_done_q;

`ifdef CAPTURE_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] line_pix_q, line_pix_d;
  logic        href_d1_q, href_d1_d;
  logic        line_err_q, line_err_d;

  always_comb begin
    frame_count_d = frame_count_q;
    line_pix_d    = line_pix_q;
    href_d1_d     = href_r_q;
    line_err_d    = line_err_q;

    if (frame_done_d) frame_count_d = frame_count_q + 16'd1;

    // Count completed pixels per line and judge the total when href drops
    if (state_q != CAPTURE || vsync_r_q) begin
      line_pix_d = '0;
    end else if (href_d1_q && !href_r_q) begin
      if (line_pix_q != 16'(H_PIXELS)) line_err_d = 1'b1;
      line_pix_d = '0;
    end else if (pend_d && line_pix_q != 16'hFFFF) begin
      line_pix_d = line_pix_q + 16'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_count_q <= '0;
      line_pix_q    <= '0;
      href_d1_q     <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      frame_count_q <= frame_count_d;
      line_pix_q    <= line_pix_d;
      href_d1_q     <= href_d1_d;
      line_err_q    <= line_err_d;
    end
  end

  assign frame_count = frame_count_q;
  assign line_err    = line_err_q;
`else
  assign frame_count = '0;
  assign line_err    = 1'b0;
`endif

endmodule

// File: doc/ov7670_capture.md
OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 Parameter: H_PIXELS, default 640, pixels per active line.
REQ-002 Parameter: V_LINES, default 480, active lines per frame; frame size H_PIXELS*V_LINES = 307200.
REQ-003 pclk  in  1  camera pixel clock; sole clock; all logic on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 vsync  in  1  camera frame sync, high = vertical blanking.
REQ-006 href  in  1  camera line valid, high = active bytes on d.
REQ-007 d  in  8  camera data byte, RGB444 two-byte format (byte0 = xxxxRRRR, byte1 = GGGGBBBB).
REQ-008 addr  out  19  frame-buffer write address of the pixel on dout.
REQ-009 dout  out  12  pixel {R[3:0],G[3:0],B[3:0]}.
REQ-010 we  out  1  frame-buffer write enable, one pclk per pixel.
REQ-011 frame_done  out  1  one-cycle pulse at end of each captured frame.
REQ-012 frame_count  out  16  captured-frame counter (CAPTURE_STATS_EN only).
REQ-013 line_err  out  1  sticky bad-line-length flag (CAPTURE_STATS_EN only).

Function
REQ-014 vsync, href and d SHALL be registered once (vsync_r, href_r, d_r) before any use.
REQ-015 FSM states: IDLE, SYNC, CAPTURE.
REQ-016 IDLE -> SYNC when vsync_r=1; no writes in IDLE.
REQ-017 SYNC -> CAPTURE when vsync_r=0; addr SHALL be held at 0 in SYNC.
REQ-018 CAPTURE -> SYNC when vsync_r=1; frame_done SHALL pulse high for exactly the cycle of this transition.
REQ-019 In CAPTURE, a byte toggle SHALL flip on every cycle href_r=1 and clear to "first byte" whenever href_r=0.
REQ-020 First byte: d_r[3:0] latched as red; second byte: dout <= {red, d_r}, we <= 1 on the next edge.
REQ-021 Latency: second byte sampled on d at edge N -> we=1 and dout valid after edge N+2.
REQ-022 we SHALL be 0 on every cycle not producing a pixel; never asserted outside CAPTURE.
REQ-023 addr SHALL increment by 1 on the cycle after each we=1; addr presented with we is that pixel's address (first pixel of frame = 0).
REQ-024 Once H_PIXELS*V_LINES pixels have been written in a frame, further pixels SHALL be dropped (we=0, addr held at 307200-1+1 not exceeded; addr saturates at 307199 for writes).
REQ-025 An odd trailing byte at href falling SHALL be discarded.
REQ-026 vsync_r rising while href_r=1 SHALL take priority: no write for the incomplete pixel, transition to SYNC.

Reset
REQ-027 rst=1 SHALL force: state IDLE, addr=0, dout=0, we=0, frame_done=0, toggle cleared, input registers 0, frame_count=0, line_err=0.
REQ-028 After rst mid-frame, capture SHALL resume only after a complete vsync high period (IDLE -> SYNC -> CAPTURE); the partial frame is never written.

Configuration
REQ-029 Macro CAPTURE_STATS_EN defined: frame_count increments (wrapping 16'hFFFF -> 0) on each frame_done; a per-line pixel counter checked at href_r falling sets line_err if count != H_PIXELS; line_err stays set until rst.
REQ-030 Macro CAPTURE_STATS_EN undefined: no counter/checker logic; frame_count tied 0, line_err tied 0; all other behaviour identical.

Verification
REQ-031 rst, then vsync high 10 cycles, low, one line of 1280 bytes alternating 8'h0A/8'hBC -> 640 we pulses, dout=12'hABC, addr 0..639, we first high 2 cycles after 2nd byte.
REQ-032 Full 640x480 frame then vsync high -> last write addr=307199, frame_done single pulse, frame_count=1 (STATS_EN).
REQ-033 Frame with 481 lines -> exactly 307200 we pulses; line 481 dropped; addr never exceeds 307199.
REQ-034 Line of 1279 bytes -> 639 pixels written, last byte discarded, line_err=1 and stays 1 through next good frame (STATS_EN); line_err=0 without macro.
REQ-035 rst asserted at line 200 of a frame, then released -> no we until vsync high then low observed; next frame starts at addr 0.
REQ-036 Start capture with vsync already low after rst -> remains IDLE, zero writes until first vsync high.
